crypto_decrypt: RTL and testbench

- Receive-side counterpart of the XOR packet encryptor on the 64-bit NetFPGA user datapath. It sits in the user data path, downstream of the output-port lookup.
- Packets whose IPv4 destination address equals match_ip have IP-header word 5 bits [47:0] and all following words XORed with the key. This restores plaintext at the far end.
- All other packets pass through bit-exact.
- Destination IP straddles words 4 and 5, so word 4 is held in a one-word register until word 5 is visible.

---
 rtl/crypto_decrypt_pkg.sv | 25 ++
 rtl/crypto_decrypt_if.sv | 30 +++
 rtl/crypto_decrypt_fifo.sv | 65 ++++++
 rtl/crypto_decrypt.sv | 187 ++++++++++++++++++
 tb/tb_crypto_decrypt.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_decrypt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | crypto_decrypt_pkg                                                     |
// | State encodings and IP-header geometry shared by the decryptor.        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package crypto_decrypt_pkg;

  localparam logic [2:0] CTRL_HDR = 3'd0;
  localparam logic [2:0] HDR      = 3'd1;
  localparam logic [2:0] HOLD     = 3'd2;
  localparam logic [2:0] EMIT4    = 3'd3;
  localparam logic [2:0] W5       = 3'd4;
  localparam logic [2:0] PAYLOAD  = 3'd5;

  localparam int FINAL_IP_HDR_WORD = 5;
  localparam int DST_IP_SPLIT      = 16;

  // Word 5 keeps its top DST_IP_SPLIT bits (tail of the destination address) in clear.
  function automatic logic [63:0] key_mask(input logic [31:0] key, input logic partial);
    key_mask = partial ? {16'h0000, key[15:0], key} : {key, key};
  endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_decrypt_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | crypto_decrypt_if                                                      |
// | Upstream write / downstream write datapath bundle.                     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface crypto_decrypt_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );
endinterface
`default_nettype wire

// File: rtl/crypto_decrypt_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | crypto_decrypt_fifo                                                    |
// | Small fallthrough FIFO: head word visible whenever not empty.          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module crypto_decrypt_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2,
  parameter int NEARLY_FULL    = (1 << MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam logic [MAX_DEPTH_BITS:0] c_depth  = (MAX_DEPTH_BITS+1)'(1 << MAX_DEPTH_BITS);
  localparam logic [MAX_DEPTH_BITS:0] c_nfull  = (MAX_DEPTH_BITS+1)'(NEARLY_FULL);

  logic [WIDTH-1:0]          r_mem [1 << MAX_DEPTH_BITS];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;
  logic                      w_full;
  logic                      w_wr;
  logic                      w_rd;

  assign w_full      = (r_count == c_depth);
  assign empty       = (r_count == '0);
  assign nearly_full = (r_count >= c_nfull);
  assign w_rd        = rd_en && !empty;
  assign w_wr        = wr_en && (!w_full || w_rd);
  assign dout        = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/crypto_decrypt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | crypto_decrypt                                                         |
// | XORs the key back out of packets addressed to match_ip; others pass.   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module crypto_decrypt #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  crypto_decrypt_if.slave      bus,
  input  logic [31:0]          key,
  input  logic [31:0]          match_ip,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] decrypt_cnt,
  output logic [CNT_WIDTH-1:0] bypass_cnt
);
  import crypto_decrypt_pkg::*;

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] w_fifo_dout;
  logic [DATA_WIDTH-1:0]            w_head_data;
  logic [CTRL_WIDTH-1:0]            w_head_ctrl;
  logic                             w_empty;
  logic                             w_nearly_full;
  logic                             w_rd;
  logic                             w_out_wr;
  logic                             w_pop_hold;
  logic                             w_pkt_end;
  logic [DATA_WIDTH-1:0]            w_out_data;
  logic [CTRL_WIDTH-1:0]            w_out_ctrl;
  logic [31:0]                      w_dst_ip;

  logic [2:0]            r_state;
  logic [2:0]            r_word_cnt;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [CTRL_WIDTH-1:0] r_hold_ctrl;
  logic                  r_hold_valid;
  logic                  r_match;
  logic                  r_cfg_valid;
  logic [31:0]           r_key_q;
  logic                  r_en_q;

  crypto_decrypt_fifo #(
    .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({bus.in_ctrl, bus.in_data}),
    .wr_en       (bus.in_wr),
    .rd_en       (w_rd),
    .dout        (w_fifo_dout),
    .nearly_full (w_nearly_full),
    .empty       (w_empty)
  );

  assign w_head_ctrl  = w_fifo_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign w_head_data  = w_fifo_dout[DATA_WIDTH-1:0];
  assign w_dst_ip     = {r_hold_data[DST_IP_SPLIT-1:0], w_head_data[DATA_WIDTH-1 -: 32-DST_IP_SPLIT]};
  assign bus.in_rdy   = !w_nearly_full;
  assign bus.out_wr   = w_out_wr;
  assign bus.out_data = w_out_data;
  assign bus.out_ctrl = w_out_ctrl;

  always_comb begin
    w_rd       = 1'b0;
    w_out_wr   = 1'b0;
    w_pop_hold = 1'b0;
    w_out_data = w_head_data;
    w_out_ctrl = w_head_ctrl;
    if (reset) begin
      case (r_state)
        CTRL_HDR, HDR: begin
          w_out_wr = !w_empty && bus.out_rdy;
          w_rd     = w_out_wr;
        end
        HOLD: begin
          // Word 4 is parked unless it already ends the packet.
          if (!w_empty) begin
            if (w_head_ctrl != '0) begin
              w_out_wr = bus.out_rdy;
              w_rd     = bus.out_rdy;
            end else begin
              w_rd       = 1'b1;
              w_pop_hold = 1'b1;
            end
          end
        end
        EMIT4: begin
          w_out_data = r_hold_data;
          w_out_ctrl = r_hold_ctrl;
          w_out_wr   = r_hold_valid && !w_empty && bus.out_rdy;
        end
        W5: begin
          w_out_data = w_head_data ^ (r_match ? key_mask(r_key_q, 1'b1) : '0);
          w_out_wr   = !w_empty && bus.out_rdy;
          w_rd       = w_out_wr;
        end
        PAYLOAD: begin
          w_out_data = w_head_data ^ (r_match ? key_mask(r_key_q, 1'b0) : '0);
          w_out_wr   = !w_empty && bus.out_rdy;
          w_rd       = w_out_wr;
        end
        default: ;
      endcase
    end
  end

  assign w_pkt_end = w_out_wr && w_rd && (w_head_ctrl != '0) && (r_state != CTRL_HDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= CTRL_HDR;
      r_word_cnt   <= 3'd1;
      r_hold_data  <= '0;
      r_hold_ctrl  <= '0;
      r_hold_valid <= 1'b0;
      r_match      <= 1'b0;
      r_cfg_valid  <= 1'b0;
      r_key_q      <= '0;
      r_en_q       <= 1'b0;
      decrypt_cnt  <= '0;
      bypass_cnt   <= '0;
    end else if (w_pkt_end) begin
      if (r_match) begin
        decrypt_cnt <= decrypt_cnt + CNT_WIDTH'(1);
      end else begin
        bypass_cnt  <= bypass_cnt + CNT_WIDTH'(1);
      end
      r_state     <= CTRL_HDR;
      r_word_cnt  <= 3'd1;
      r_match     <= 1'b0;
      r_cfg_valid <= 1'b0;
    end else begin
      case (r_state)
        CTRL_HDR: begin
          if (w_out_wr) begin
            // Key and enable are frozen for the whole packet at its first word.
            if (!r_cfg_valid) begin
              r_key_q     <= key;
              r_en_q      <= enable;
              r_cfg_valid <= 1'b1;
            end
            if (w_head_ctrl == '0) begin
              r_state    <= HDR;
              r_word_cnt <= 3'd2;
            end
          end
        end
        HDR: begin
          if (w_out_wr) begin
            if (r_word_cnt == 3'(FINAL_IP_HDR_WORD - 2)) begin
              r_state <= HOLD;
            end
            r_word_cnt <= r_word_cnt + 3'd1;
          end
        end
        HOLD: begin
          if (w_pop_hold) begin
            r_hold_data  <= w_head_data;
            r_hold_ctrl  <= w_head_ctrl;
            r_hold_valid <= 1'b1;
            r_state      <= EMIT4;
          end
        end
        EMIT4: begin
          if (w_out_wr) begin
            r_match      <= r_en_q && (w_dst_ip == match_ip);
            r_hold_valid <= 1'b0;
            r_word_cnt   <= 3'(FINAL_IP_HDR_WORD);
            r_state      <= W5;
          end
        end
        W5: begin
          if (w_out_wr) begin
            r_state <= PAYLOAD;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_crypto_decrypt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_crypto_decrypt                                                      |
// | Randomised scoreboard bench against a per-packet reference model.      |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_crypto_decrypt;
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] key = '0;
  logic [31:0] match_ip = '0;
  logic        enable = 1'b0;
  logic [31:0] decrypt_cnt;
  logic [31:0] bypass_cnt;

  crypto_decrypt_if #(.DATA_WIDTH(64)) bus_if ();

  crypto_decrypt #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .key         (key),
    .match_ip    (match_ip),
    .enable      (enable),
    .decrypt_cnt (decrypt_cnt),
    .bypass_cnt  (bypass_cnt)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  word_t pkt[$];
  int    checks = 0;
  int    failures = 0;
  int    hdr_out = 0;
  int    hdr_sent = 0;
  int    exp_dec = 0;
  int    exp_byp = 0;
  bit    rdy_rand = 1'b0;
  bit    bursty = 1'b0;

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (exp_q=%0d hdr_out=%0d hdr_sent=%0d)", name, exp_q.size(), hdr_out, hdr_sent);
    finish_run();
  endtask

  // Monitor: each negedge with out_wr high is exactly one transfer at the next posedge.
  always @(negedge clk) begin
    word_t got;
    word_t e;
    if (reset) begin
      if (bus_if.out_wr) begin
        got = '{ctrl: bus_if.out_ctrl, data: bus_if.out_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_word got=%h expected=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL out_word got=%h expected=%h", got, e);
          end
        end
        if (bus_if.out_ctrl == 8'hFF) hdr_out++;
      end
    end else begin
      check("out_wr_in_reset", {63'd0, bus_if.out_wr}, 64'd0);
    end
  end

  initial begin
    bus_if.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.out_rdy = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic send_word(input word_t w);
    int guard = 0;
    if (bursty && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    while (!bus_if.in_rdy) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 5000) timeout("in_rdy_wait");
    end
    bus_if.in_data = w.data;
    bus_if.in_ctrl = w.ctrl;
    bus_if.in_wr   = 1'b1;
    if (w.ctrl == 8'hFF) hdr_sent++;
    @(posedge clk); #1;
    bus_if.in_wr = 1'b0;
  endtask

  // Config may only change once every header already sent has left the DUT.
  task automatic wait_hdr_drain();
    int guard = 0;
    while (hdr_out != hdr_sent) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 5000) timeout("hdr_drain");
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) timeout("drain");
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // One module header, then n words; dst IP split across words 4 and 5.
  task automatic build_pkt(input int n, input logic [31:0] dst);
    word_t w;
    pkt.delete();
    pkt.push_back('{ctrl: 8'hFF, data: {$urandom, $urandom}});
    for (int k = 1; k <= n; k++) begin
      w.data = {$urandom, $urandom};
      w.ctrl = (k == n) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if (k == 4) w.data[15:0] = dst[31:16];
      if (k == 5) w.data[63:48] = dst[15:0];
      pkt.push_back(w);
    end
  endtask

  // Reference: decrypt iff the packet reaches word 5, enable is set and the destination matches.
  function automatic void model_push(input logic [31:0] k, input logic [31:0] mip, input logic en);
    int    n = pkt.size() - 1;
    logic  hit;
    word_t w;
    hit = (n >= 5) && en && ({pkt[4].data[15:0], pkt[5].data[63:48]} == mip);
    for (int i = 0; i < pkt.size(); i++) begin
      w = pkt[i];
      if (hit && i == 5) w.data[47:0] = w.data[47:0] ^ {k[15:0], k};
      if (hit && i > 5)  w.data = w.data ^ {k, k};
      exp_q.push_back(w);
    end
    if (hit) exp_dec++; else exp_byp++;
  endfunction

  task automatic run_pkt(input int n, input logic [31:0] dst, input logic [31:0] k,
                         input logic [31:0] mip, input logic en, input int key_swap_at);
    wait_hdr_drain();
    key = k; match_ip = mip; enable = en;
    build_pkt(n, dst);
    model_push(k, mip, en);
    for (int i = 0; i < pkt.size(); i++) begin
      send_word(pkt[i]);
      if (i == key_swap_at) begin
        wait_hdr_drain();
        key = ~k;
      end
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_decrypt_cnt"}, 64'(decrypt_cnt), 64'(exp_dec));
    check({tag, "_bypass_cnt"},  64'(bypass_cnt),  64'(exp_byp));
  endtask

  initial begin
    int base_dec;
    int base_byp;
    logic [31:0] mip;
    bus_if.in_wr = 1'b0;
    bus_if.in_data = '0;
    bus_if.in_ctrl = '0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_decrypt_cnt", 64'(decrypt_cnt), 64'd0);
    check("reset_bypass_cnt", 64'(bypass_cnt), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_in_rdy", {63'd0, bus_if.in_rdy}, 64'd1);
    check("idle_out_wr", {63'd0, bus_if.out_wr}, 64'd0);

    // Known-answer packet with literal expectations.
    key = 32'h01234567; match_ip = 32'hC0A80004; enable = 1'b1;
    build_pkt(6, 32'hC0A80004);
    pkt[5] = '{ctrl: 8'h00, data: 64'h0004AAAABBBBCCCC};
    pkt[6] = '{ctrl: 8'h80, data: 64'h0000000000000000};
    for (int i = 0; i < 5; i++) exp_q.push_back(pkt[i]);
    exp_q.push_back('{ctrl: 8'h00, data: 64'h0004EFCDBA9889AB});
    exp_q.push_back('{ctrl: 8'h80, data: 64'h0123456701234567});
    exp_dec++;
    for (int i = 0; i < pkt.size(); i++) send_word(pkt[i]);
    drain();
    check_counts("kat");

    run_pkt(8, 32'hC0A80005, 32'h01234567, 32'hC0A80004, 1'b1, -1);
    drain();
    check_counts("nomatch");
    run_pkt(8, 32'hC0A80004, 32'h01234567, 32'hC0A80004, 1'b0, -1);
    drain();
    check_counts("disabled");
    run_pkt(3, 32'hC0A80004, 32'h89ABCDEF, 32'hC0A80004, 1'b1, -1);
    run_pkt(4, 32'hC0A80004, 32'h89ABCDEF, 32'hC0A80004, 1'b1, -1);
    run_pkt(5, 32'hC0A80004, 32'h89ABCDEF, 32'hC0A80004, 1'b1, -1);
    run_pkt(9, 32'hC0A80004, 32'h89ABCDEF, 32'hC0A80004, 1'b1, -1);
    drain();
    check_counts("short");

    // Mixed traffic with random back-pressure and bursty writes.
    rdy_rand = 1'b1;
    bursty = 1'b1;
    base_dec = exp_dec;
    base_byp = exp_byp;
    mip = $urandom;
    for (int p = 0; p < 100; p++) begin
      run_pkt($urandom_range(2, 12), ($urandom_range(0, 1) == 1) ? mip : $urandom,
              $urandom, mip, ($urandom_range(0, 9) != 0), -1);
    end
    drain();
    check_counts("random");
    check("random_pkt_total", 64'((decrypt_cnt - 32'(base_dec)) + (bypass_cnt - 32'(base_byp))), 64'd100);

    // Key swapped after payload has started: the packet keeps its original key.
    run_pkt(12, mip, 32'hA5A55A5A, mip, 1'b1, 8);
    run_pkt(7, mip, 32'h3C3CC3C3, mip, 1'b1, -1);
    drain();
    check_counts("key_swap");

    // Reset pulse mid-payload abandons the packet and clears all state.
    wait_hdr_drain();
    key = 32'h0F0F1234; match_ip = mip; enable = 1'b1;
    build_pkt(12, mip);
    model_push(key, mip, enable);
    for (int i = 0; i < 8; i++) send_word(pkt[i]);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    check("midreset_decrypt_cnt", 64'(decrypt_cnt), 64'd0);
    check("midreset_bypass_cnt", 64'(bypass_cnt), 64'd0);
    exp_dec = 0;
    exp_byp = 0;
    hdr_sent = hdr_out;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_rdy", {63'd0, bus_if.in_rdy}, 64'd1);
    run_pkt(10, mip, 32'h77665544, mip, 1'b1, -1);
    run_pkt(6, mip ^ 32'h1, 32'h77665544, mip, 1'b1, -1);
    drain();
    check_counts("post_reset");

    rdy_rand = 1'b0;
    finish_run();
  end
endmodule
`default_nettype wire
